// File: rtl/pong_pkg.sv
// Shared Pong datapath constants and the paddle direction encoding.
package pong_pkg;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam int PAD_W = 4;
  localparam int PAD_H = 72;

  // Lowest legal top row: the paddle's bottom row sits on Y_MAX.
  localparam int TOP_LIMIT = Y_MAX + 1 - PAD_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } pad_dir_e;

endpackage

// File: rtl/paddle_axis.sv
// One vertical paddle: command select, direction FSM, acceleration, edge clamp
// and the pixel-in-box test for the video path.
module paddle_axis
  import pong_pkg::*;
#(
  parameter logic [9:0] X_LEFT       = 10'd36,
  parameter int         Y_RESET      = 204,
  parameter int         V_MIN        = 1,
  parameter int         V_MAX        = 6,
  parameter int         ACCEL_FRAMES = 4,
  parameter int         DEADBAND     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       up,
  input  logic       down,
  input  logic       auto_en,
  input  logic [9:0] ball_y,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] pad_t,
  output logic [9:0] pad_b,
  output logic [9:0] pad_l,
  output logic [9:0] pad_r,
  output logic       pad_on
);

  localparam logic [9:0]         TOP_RESET  = 10'(Y_RESET);
  localparam logic [9:0]         BOT_RESET  = 10'(Y_RESET + PAD_H - 1);
  localparam logic [9:0]         BOX_H      = 10'(PAD_H - 1);
  localparam logic [9:0]         X_RIGHT    = X_LEFT + 10'(PAD_W - 1);
  localparam logic [3:0]         SPD_MIN    = 4'(V_MIN);
  localparam logic [3:0]         SPD_MAX    = 4'(V_MAX);
  localparam logic [3:0]         HOLD_LAST  = 4'(ACCEL_FRAMES - 1);
  // The entry frame already counts as the first held frame of a new direction.
  localparam logic [3:0]         HOLD_ENTRY = (ACCEL_FRAMES > 1) ? 4'd1 : 4'd0;
  localparam logic [11:0]        HALF_H     = 12'(PAD_H / 2);
  localparam logic [11:0]        DEAD       = 12'(DEADBAND);
  localparam logic signed [10:0] TOP_LIM_S  = 11'(TOP_LIMIT);

  pad_dir_e           state_r;
  pad_dir_e           cmd_s;
  logic [3:0]         speed_r;
  logic [3:0]         speed_s;
  logic [3:0]         hold_r;
  logic [3:0]         hold_s;
  logic [9:0]         top_r;
  logic [9:0]         bot_r;
  logic [9:0]         top_s;
  logic [11:0]        centre_s;
  logic [11:0]        ball_s;
  logic signed [10:0] moved_s;

  // Command select: ball follow with a dead zone, or the manual buttons.
  always_comb begin
    cmd_s    = IDLE;
    centre_s = {2'b00, top_r} + HALF_H;
    ball_s   = {2'b00, ball_y};
    if (auto_en) begin
      if (ball_s + DEAD < centre_s) begin
        cmd_s = UP;
      end else if (ball_s > centre_s + DEAD) begin
        cmd_s = DOWN;
      end else begin
        cmd_s = IDLE;
      end
    end else begin
      case ({up, down})
        2'b10:   cmd_s = UP;
        2'b01:   cmd_s = DOWN;
        default: cmd_s = IDLE;
      endcase
    end
  end

  // Speed ramp: restart on any direction change, step up every ACCEL_FRAMES held frames.
  always_comb begin
    speed_s = speed_r;
    hold_s  = hold_r;
    if (cmd_s == IDLE) begin
      speed_s = SPD_MIN;
      hold_s  = 4'd0;
    end else if (cmd_s != state_r) begin
      speed_s = SPD_MIN;
      hold_s  = HOLD_ENTRY;
    end else if (hold_r >= HOLD_LAST) begin
      hold_s  = 4'd0;
      speed_s = (speed_r < SPD_MAX) ? speed_r + 4'd1 : SPD_MAX;
    end else begin
      hold_s  = hold_r + 4'd1;
    end
  end

  // Move by the freshly updated speed; signed arithmetic keeps the clamp from wrapping.
  always_comb begin
    moved_s = $signed({1'b0, top_r});
    top_s   = top_r;
    case (cmd_s)
      UP: begin
        moved_s = $signed({1'b0, top_r}) - $signed({7'd0, speed_s});
        if (moved_s < 11'sd0) begin
          top_s = 10'd0;
        end else begin
          top_s = moved_s[9:0];
        end
      end
      DOWN: begin
        moved_s = $signed({1'b0, top_r}) + $signed({7'd0, speed_s});
        if (moved_s > TOP_LIM_S) begin
          top_s = TOP_LIM_S[9:0];
        end else begin
          top_s = moved_s[9:0];
        end
      end
      default: begin
        top_s = top_r;
      end
    endcase
  end

  // Frame-rate state update; everything holds between ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      speed_r <= SPD_MIN;
      hold_r  <= 4'd0;
      top_r   <= TOP_RESET;
      bot_r   <= BOT_RESET;
    end else if (frame_tick) begin
      state_r <= cmd_s;
      speed_r <= speed_s;
      hold_r  <= hold_s;
      top_r   <= top_s;
      bot_r   <= top_s + BOX_H;
    end
  end

  assign pad_t  = top_r;
  assign pad_b  = bot_r;
  assign pad_l  = X_LEFT;
  assign pad_r  = X_RIGHT;
  assign pad_on = (x >= X_LEFT) && (x <= X_RIGHT) && (y >= top_r) && (y <= bot_r);

endmodule

// File: rtl/paddle_bank.sv
// Bank of NUM_PAD independent paddles with packed bounding-box outputs.
module paddle_bank
  import pong_pkg::*;
#(
  parameter int                    NUM_PAD      = 2,
  parameter logic [NUM_PAD*10-1:0] X_LEFT       = {10'd600, 10'd36},
  parameter int                    Y_RESET      = 204,
  parameter int                    V_MIN        = 1,
  parameter int                    V_MAX        = 6,
  parameter int                    ACCEL_FRAMES = 4,
  parameter int                    DEADBAND     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic [NUM_PAD-1:0]    up,
  input  logic [NUM_PAD-1:0]    down,
  input  logic [NUM_PAD-1:0]    auto_en,
  input  logic [9:0]            ball_y,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  output logic [10*NUM_PAD-1:0] pad_t,
  output logic [10*NUM_PAD-1:0] pad_b,
  output logic [10*NUM_PAD-1:0] pad_l,
  output logic [10*NUM_PAD-1:0] pad_r,
  output logic [NUM_PAD-1:0]    pad_on
);

  for (genvar i = 0; i < NUM_PAD; i++) begin : g_pad
    paddle_axis #(
      .X_LEFT       (X_LEFT[10*i +: 10]),
      .Y_RESET      (Y_RESET),
      .V_MIN        (V_MIN),
      .V_MAX        (V_MAX),
      .ACCEL_FRAMES (ACCEL_FRAMES),
      .DEADBAND     (DEADBAND)
    ) u_axis (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .up         (up[i]),
      .down       (down[i]),
      .auto_en    (auto_en[i]),
      .ball_y     (ball_y),
      .x          (x),
      .y          (y),
      .pad_t      (pad_t[10*i +: 10]),
      .pad_b      (pad_b[10*i +: 10]),
      .pad_l      (pad_l[10*i +: 10]),
      .pad_r      (pad_r[10*i +: 10]),
      .pad_on     (pad_on[i])
    );
  end

endmodule

// File: tb/tb_paddle_bank.sv
// Randomised scoreboard bench for paddle_bank against a frame-level paddle model.
module tb_paddle_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [1:0]  up, down, auto_en;
  logic [9:0]  ball_y, x, y;
  logic [19:0] pad_t, pad_b, pad_l, pad_r;
  logic [1:0]  pad_on;

  paddle_bank dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .up(up), .down(down), .auto_en(auto_en), .ball_y(ball_y),
    .x(x), .y(y),
    .pad_t(pad_t), .pad_b(pad_b), .pad_l(pad_l), .pad_r(pad_r), .pad_on(pad_on)
  );

  always #5 clk = ~clk;

  typedef struct { logic [19:0] t; logic [19:0] b; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Frame-level model: top row, last direction, frames held in that direction.
  int m_top[2];
  int m_dir[2];
  int m_n[2];
  int m_left[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_top[i] = 204;
      m_dir[i] = 0;
      m_n[i]   = 0;
    end
  endfunction

  function automatic void model_tick(input logic [1:0] u, input logic [1:0] d,
                                     input logic [1:0] a, input int by);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      int c, cmd, spd;
      c = m_top[i] + 36;
      if (a[i]) cmd = (by + 8 < c) ? 1 : ((by > c + 8) ? 2 : 0);
      else      cmd = (u[i] && !d[i]) ? 1 : ((d[i] && !u[i]) ? 2 : 0);
      if (cmd == 0)             m_n[i] = 0;
      else if (cmd == m_dir[i]) m_n[i] = m_n[i] + 1;
      else                      m_n[i] = 1;
      spd = (cmd == 0) ? 1 : 1 + m_n[i] / 4;
      if (spd > 6) spd = 6;
      if (cmd == 1) m_top[i] = (m_top[i] - spd < 0) ? 0 : m_top[i] - spd;
      if (cmd == 2) m_top[i] = (m_top[i] + spd > 408) ? 408 : m_top[i] + spd;
      m_dir[i] = cmd;
      e.t[10*i +: 10] = 10'(m_top[i]);
      e.b[10*i +: 10] = 10'(m_top[i] + 71);
    end
    q.push_back(e);
  endfunction

  task automatic do_tick(input logic [1:0] u, input logic [1:0] d,
                         input logic [1:0] a, input int by);
    @(negedge clk);
    up = u; down = d; auto_en = a; ball_y = 10'(by);
    frame_tick = 1'b1;
    model_tick(u, d, a, by);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_top", int'(pad_t), (204 << 10) | 204);
    chk("rst_bot", int'(pad_b), (275 << 10) | 275);
    #3 reset = 1'b0;
  endtask

  task automatic check_on();
    for (int k = 0; k < 4; k++) begin
      int p, xi, yi;
      logic [1:0] ex;
      p  = $urandom_range(0, 1);
      xi = m_left[p] + $urandom_range(0, 6) - 1;
      yi = m_top[p] + $urandom_range(0, 75) - 2;
      if (yi < 0) yi = 0;
      x = 10'(xi); y = 10'(yi);
      #1;
      for (int i = 0; i < 2; i++)
        ex[i] = (xi >= m_left[i]) && (xi <= m_left[i] + 3) &&
                (yi >= m_top[i]) && (yi <= m_top[i] + 71);
      chk("pad_on", int'(pad_on), int'(ex));
    end
  endtask

  // Monitor: every frame tick the DUT presents new boxes; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick === 1'b1 && reset === 1'b0) begin
        #1;
        if (q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          chk("tick_top", int'(pad_t), int'(e.t));
          chk("tick_bot", int'(pad_b), int'(e.b));
        end
      end
    end
  end

  initial begin
    int diff, c;
    m_left[0] = 36; m_left[1] = 600;
    reset = 1'b1; frame_tick = 1'b0;
    up = 2'b00; down = 2'b00; auto_en = 2'b00; ball_y = 10'd0; x = 10'd0; y = 10'd0;
    model_reset();
    #12 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, no tick
    chk("t1_top0", int'(pad_t[9:0]), 204);
    chk("t1_top1", int'(pad_t[19:10]), 204);
    chk("t1_bot0", int'(pad_b[9:0]), 275);
    chk("t1_bot1", int'(pad_b[19:10]), 275);
    chk("t1_l0", int'(pad_l[9:0]), 36);
    chk("t1_r0", int'(pad_r[9:0]), 39);
    chk("t1_l1", int'(pad_l[19:10]), 600);
    chk("t1_r1", int'(pad_r[19:10]), 603);
    check_on();

    // Acceleration on a held up button
    repeat (12) do_tick(2'b01, 2'b00, 2'b00, 0);
    chk("t2_top0", int'(pad_t[9:0]), 177);

    // Bottom clamp
    do_reset();
    repeat (50) do_tick(2'b00, 2'b10, 2'b00, 0);
    chk("t3_top1", int'(pad_t[19:10]), 408);
    chk("t3_bot1", int'(pad_b[19:10]), 479);

    // Both buttons pressed is no request; then slow restart
    do_reset();
    repeat (5) do_tick(2'b01, 2'b01, 2'b00, 0);
    repeat (3) do_tick(2'b01, 2'b00, 2'b00, 0);
    chk("t4_top0", int'(pad_t[9:0]), 201);

    // Auto-track towards the ball, then stillness without ticks
    do_reset();
    repeat (40) do_tick(2'b00, 2'b00, 2'b10, 100);
    c = int'(pad_t[19:10]) + 36;
    diff = (c > 100) ? c - 100 : 100 - c;
    chk("t5_settle", int'(diff <= 8), 1);
    repeat (5) begin
      @(negedge clk);
      ball_y = 10'($urandom_range(0, 479));
      up = 2'($urandom); down = 2'($urandom);
    end
    chk("t5_hold", int'(pad_t[19:10]), m_top[1]);

    // Reset during an accelerating hold
    do_reset();
    repeat (9) do_tick(2'b01, 2'b00, 2'b00, 0);
    do_reset();
    do_tick(2'b01, 2'b00, 2'b00, 0);
    chk("t6_top0", int'(pad_t[9:0]), 203);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] ru, rd, ra;
      ru = 2'($urandom); rd = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(0, 7) != 0) begin
        do_tick(ru, rd, ra, $urandom_range(0, 479));
      end else begin
        do_reset();
      end
      if ((n % 25) == 0) check_on();
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
